// File: rtl/antirrebote_sensores.sv
// Two-channel barrier front end: synchronises btn_A/btn_B, debounces each with a
// stability counter and emits registered one-cycle rise/fall pulses per channel.
module antirrebote_sensores #(
  parameter int DEBOUNCE_CYCLES = 5000,
  parameter int CNT_W           = 13
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_A,
  input  logic btn_B,
  output logic A_db,
  output logic B_db,
  output logic A_rise,
  output logic A_fall,
  output logic B_rise,
  output logic B_fall
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0] raw;
  logic [1:0] db;
  logic [1:0] rise;
  logic [1:0] fall;

  assign raw = {btn_B, btn_A};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ch
      logic             s1;
      logic             s2;
      logic             db_r;
      logic             rise_r;
      logic             fall_r;
      logic [CNT_W-1:0] cnt;
      logic             mismatch;
      logic             done;

      // The level only flips after a full uninterrupted run of mismatching samples.
      assign mismatch = s2 ^ db_r;
      assign done     = mismatch & (cnt == LAST);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s1     <= 1'b0;
          s2     <= 1'b0;
          db_r   <= 1'b0;
          rise_r <= 1'b0;
          fall_r <= 1'b0;
          cnt    <= '0;
        end else begin
          s1     <= raw[gi];
          s2     <= s1;
          rise_r <= done & s2;
          fall_r <= done & ~s2;
          if (!mismatch) begin
            cnt <= '0;
          end else if (done) begin
            cnt  <= '0;
            db_r <= s2;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
      end

      assign db[gi]   = db_r;
      assign rise[gi] = rise_r;
      assign fall[gi] = fall_r;
    end
  endgenerate

  assign A_db   = db[0];
  assign B_db   = db[1];
  assign A_rise = rise[0];
  assign A_fall = fall[0];
  assign B_rise = rise[1];
  assign B_fall = fall[1];

endmodule

// File: tb/tb_antirrebote_sensores.sv
// Bench for antirrebote_sensores: directed latency/bounce/reset scenarios at
// DEBOUNCE_CYCLES=4, randomized bounce against a window model, and a full-size entry run.
module tb_antirrebote_sensores;

  localparam int D = 4;

  logic clk = 1'b0;
  logic rst;
  logic btn_a, btn_b;
  logic a_db, b_db, a_rise, a_fall, b_rise, b_fall;
  logic big_a, big_b;
  logic big_a_db, big_b_db, big_a_rise, big_a_fall, big_b_rise, big_b_fall;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  antirrebote_sensores #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .btn_A(btn_a), .btn_B(btn_b),
    .A_db(a_db), .B_db(b_db), .A_rise(a_rise), .A_fall(a_fall),
    .B_rise(b_rise), .B_fall(b_fall)
  );

  antirrebote_sensores dut_big (
    .clk(clk), .rst(rst), .btn_A(big_a), .btn_B(big_b),
    .A_db(big_a_db), .B_db(big_b_db), .A_rise(big_a_rise), .A_fall(big_a_fall),
    .B_rise(big_b_rise), .B_fall(big_b_fall)
  );

  // Reference: a raw sample taken at one edge is seen two edges later; the level
  // flips once the last D seen samples since the previous flip all disagree with it.
  bit [1:0] exp_db, exp_rise, exp_fall;
  bit       raw_h  [2][2];
  bit       seen_h [2][D];
  int       since  [2];

  always @(posedge clk or posedge rst) begin
    bit seen, flip, cur;
    if (rst) begin
      exp_db   <= '0;
      exp_rise <= '0;
      exp_fall <= '0;
      for (int c = 0; c < 2; c++) begin
        raw_h[c][0] = 1'b0;
        raw_h[c][1] = 1'b0;
        since[c]    = 0;
        for (int i = 0; i < D; i++) seen_h[c][i] = 1'b0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        cur  = (c == 0) ? btn_a : btn_b;
        seen = raw_h[c][1];
        raw_h[c][1] = raw_h[c][0];
        raw_h[c][0] = cur;
        for (int i = D - 1; i > 0; i--) seen_h[c][i] = seen_h[c][i-1];
        seen_h[c][0] = seen;
        if (since[c] < D) since[c]++;
        flip = (since[c] >= D);
        for (int i = 0; i < D; i++)
          if (seen_h[c][i] == exp_db[c]) flip = 1'b0;
        exp_rise[c] <= flip & seen;
        exp_fall[c] <= flip & ~seen;
        if (flip) begin
          exp_db[c] <= seen;
          since[c]  = 0;
        end
      end
    end
  end

  task automatic apply_reset();
    rst   = 1'b1;
    btn_a = 1'b0;
    btn_b = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    btn_a = 1'b0;
    btn_b = 1'b0;
    repeat (2) @(negedge clk);
    btn_a = 1'b1;
    repeat (4) begin
      @(negedge clk);
      n_checks++;
      if ({a_db, b_db, a_rise, a_fall, b_rise, b_fall} !== 6'b0) begin
        n_fail++;
        $display("FAIL reset_hold: outputs=%b required=000000",
                 {a_db, b_db, a_rise, a_fall, b_rise, b_fall});
      end
    end
    rst = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      n_checks++;
      if (a_db !== (k >= 6) || a_rise !== (k == 6) || a_fall !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_release cycle %0d: db=%b rise=%b fall=%b required db=%b rise=%b fall=0",
                 k, a_db, a_rise, a_fall, k >= 6, k == 6);
      end
    end
  endtask

  task automatic test_step();
    apply_reset();
    btn_a = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      n_checks++;
      if (a_db !== (k >= 6) || a_rise !== (k == 6) || a_fall !== 1'b0) begin
        n_fail++;
        $display("FAIL step_rise cycle %0d: db=%b rise=%b fall=%b required db=%b rise=%b fall=0",
                 k, a_db, a_rise, a_fall, k >= 6, k == 6);
      end
    end
    btn_a = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      n_checks++;
      if (a_db !== (k < 6) || a_fall !== (k == 6) || a_rise !== 1'b0) begin
        n_fail++;
        $display("FAIL step_fall cycle %0d: db=%b rise=%b fall=%b required db=%b rise=0 fall=%b",
                 k, a_db, a_rise, a_fall, k < 6, k == 6);
      end
    end
  endtask

  task automatic test_bounce();
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      btn_b = (i % 2 == 0);
      repeat (2) begin
        @(negedge clk);
        n_checks++;
        if ({b_db, b_rise, b_fall} !== 3'b000) begin
          n_fail++;
          $display("FAIL bounce_reject seg %0d: db/rise/fall=%b required 000", i, {b_db, b_rise, b_fall});
        end
      end
    end
    btn_b = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      n_checks++;
      if (b_db !== (k >= 6) || b_rise !== (k == 6) || b_fall !== 1'b0) begin
        n_fail++;
        $display("FAIL bounce_hold cycle %0d: db=%b rise=%b fall=%b required db=%b rise=%b fall=0",
                 k, b_db, b_rise, b_fall, k >= 6, k == 6);
      end
    end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    btn_a = 1'b1;
    btn_b = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      n_checks++;
      if ({a_rise, b_rise} !== ((k == 6) ? 2'b11 : 2'b00) ||
          {a_db, b_db} !== ((k >= 6) ? 2'b11 : 2'b00)) begin
        n_fail++;
        $display("FAIL simultaneous cycle %0d: rise=%b db=%b required rise=%b db=%b",
                 k, {a_rise, b_rise}, {a_db, b_db}, (k == 6) ? 2'b11 : 2'b00, (k >= 6) ? 2'b11 : 2'b00);
      end
    end
  endtask

  task automatic test_reset_mid_count();
    apply_reset();
    btn_a = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if ({a_db, a_rise} !== 2'b00) begin
        n_fail++;
        $display("FAIL midcount_hold: db/rise=%b required 00", {a_db, a_rise});
      end
    end
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      n_checks++;
      if (a_db !== (k >= 6) || a_rise !== (k == 6)) begin
        n_fail++;
        $display("FAIL midcount_requalify cycle %0d: db=%b rise=%b required db=%b rise=%b",
                 k, a_db, a_rise, k >= 6, k == 6);
      end
    end
  endtask

  task automatic test_random();
    int hold_a, hold_b;
    logic [5:0] obs, exp;
    apply_reset();
    hold_a = 0;
    hold_b = 0;
    for (int t = 0; t < 800; t++) begin
      @(negedge clk);
      obs = {a_db, b_db, a_rise, b_rise, a_fall, b_fall};
      exp = {exp_db[0], exp_db[1], exp_rise[0], exp_rise[1], exp_fall[0], exp_fall[1]};
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL random cycle %0d: db,rise,fall=%b required %b", t, obs, exp);
      end
      if (hold_a == 0) begin
        btn_a  = 1'($urandom_range(0, 1));
        hold_a = $urandom_range(1, 7);
      end
      if (hold_b == 0) begin
        btn_b  = 1'($urandom_range(0, 1));
        hold_b = $urandom_range(1, 7);
      end
      hold_a--;
      hold_b--;
    end
  endtask

  task automatic test_entry_sequence();
    bit [1:0] phase_in [4];
    int pc [4];
    int first [4];
    logic [3:0] pulses;
    phase_in[0] = 2'b01;  // {B,A}
    phase_in[1] = 2'b11;
    phase_in[2] = 2'b10;
    phase_in[3] = 2'b00;
    apply_reset();
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 4; i++) begin
        pc[i]    = 0;
        first[i] = -1;
      end
      big_a = phase_in[p][0];
      big_b = phase_in[p][1];
      for (int k = 1; k <= 10000; k++) begin
        @(negedge clk);
        pulses = {big_b_fall, big_a_fall, big_b_rise, big_a_rise};
        for (int i = 0; i < 4; i++) begin
          if (pulses[i] === 1'b1) begin
            pc[i]++;
            if (first[i] < 0) first[i] = k;
          end
        end
      end
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (pc[i] !== ((i == p) ? 1 : 0) || (i == p && first[i] != 5002)) begin
          n_fail++;
          $display("FAIL entry phase %0d pulse %0d: count=%0d at cycle %0d required count=%0d at cycle 5002",
                   p, i, pc[i], first[i], (i == p) ? 1 : 0);
        end
      end
      n_checks++;
      if ({big_b_db, big_a_db} !== phase_in[p]) begin
        n_fail++;
        $display("FAIL entry_level phase %0d: db=%b required %b", p, {big_b_db, big_a_db}, phase_in[p]);
      end
    end
  endtask

  initial begin
    rst   = 1'b1;
    btn_a = 1'b0;
    btn_b = 1'b0;
    big_a = 1'b0;
    big_b = 1'b0;
    test_reset();
    test_step();
    test_bounce();
    test_simultaneous();
    test_reset_mid_count();
    test_random();
    test_entry_sequence();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
